// File: rtl/fcmp_pipe.sv
// fcmp_pipe: two-stage pipelined binary32 compare unit (FEQ / FLT / FLE).
// Stage 1 classifies both operands and compares their magnitudes.
// Stage 2 forms the result and the invalid-operation flag.
// Denormals are compared exactly; there is no flush-to-zero.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The producer holds its payload stable while valid && !ready.
// The out_* payload stays stable while out_valid && !out_ready.
// in_ready depends on out_ready and pipeline occupancy only, never on in_valid.
module fcmp_pipe #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_y,
    output logic             out_nv,
    output logic [TAG_W-1:0] out_tag
);

    // Operand classes. Bit 1 set means NaN of either kind.
    localparam logic [1:0] CLS_OTHER = 2'd0;
    localparam logic [1:0] CLS_ZERO  = 2'd1;
    localparam logic [1:0] CLS_SNAN  = 2'd2;
    localparam logic [1:0] CLS_QNAN  = 2'd3;

    localparam logic [1:0] OP_FEQ = 2'd0;
    localparam logic [1:0] OP_FLT = 2'd1;
    localparam logic [1:0] OP_FLE = 2'd2;

    function automatic logic [1:0] classify(input logic [31:0] x);
        logic [1:0] c;
        c = CLS_OTHER;
        if (x[30:23] == 8'hFF && x[22:0] != 23'd0) begin
            c = x[22] ? CLS_QNAN : CLS_SNAN;
        end else if (x[30:0] == 31'd0) begin
            c = CLS_ZERO;
        end
        return c;
    endfunction

    // Stage 1 state
    logic             s1_valid;
    logic [1:0]       s1_cls1;
    logic [1:0]       s1_cls2;
    logic             s1_sgn1;
    logic             s1_sgn2;
    logic             s1_mag_lt;
    logic             s1_mag_eq;
    logic [1:0]       s1_op;
    logic [TAG_W-1:0] s1_tag;

    // Flow control
    logic s2_adv;
    logic s1_adv;

    // Stage 2 combinational result
    logic any_nan;
    logic any_snan;
    logic both_zero;
    logic eq_c;
    logic lt_c;
    logic y_c;
    logic nv_c;

    // Advance conditions: S2 drains when empty or consumed, S1 when empty or S2 moves.
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv;
    end

    // Stage 1 register: classify operands and compare magnitudes on accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid  <= 1'b0;
            s1_cls1   <= CLS_OTHER;
            s1_cls2   <= CLS_OTHER;
            s1_sgn1   <= 1'b0;
            s1_sgn2   <= 1'b0;
            s1_mag_lt <= 1'b0;
            s1_mag_eq <= 1'b0;
            s1_op     <= 2'd0;
            s1_tag    <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_cls1   <= classify(in_x1);
                s1_cls2   <= classify(in_x2);
                s1_sgn1   <= in_x1[31];
                s1_sgn2   <= in_x2[31];
                s1_mag_lt <= in_x1[30:0] < in_x2[30:0];
                s1_mag_eq <= in_x1[30:0] == in_x2[30:0];
                s1_op     <= in_op;
                s1_tag    <= in_tag;
            end
        end
    end

    // Stage 2 logic: ordered equality / less-than and the per-op NV rule.
    always_comb begin
        any_nan   = s1_cls1[1] | s1_cls2[1];
        any_snan  = (s1_cls1 == CLS_SNAN) | (s1_cls2 == CLS_SNAN);
        both_zero = (s1_cls1 == CLS_ZERO) && (s1_cls2 == CLS_ZERO);
        eq_c      = !any_nan && (both_zero || (s1_sgn1 == s1_sgn2 && s1_mag_eq));
        lt_c      = !any_nan && !both_zero &&
                    (( s1_sgn1 && !s1_sgn2) ||
                     (!s1_sgn1 && !s1_sgn2 && s1_mag_lt) ||
                     ( s1_sgn1 &&  s1_sgn2 && !s1_mag_lt && !s1_mag_eq));
        y_c  = 1'b0;
        nv_c = 1'b0;
        case (s1_op)
            OP_FEQ: begin
                y_c  = eq_c;
                nv_c = any_snan;
            end
            OP_FLT: begin
                y_c  = lt_c;
                nv_c = any_nan;
            end
            OP_FLE: begin
                y_c  = lt_c | eq_c;
                nv_c = any_nan;
            end
            default: begin
                y_c  = 1'b0;
                nv_c = 1'b0;
            end
        endcase
    end

    // Stage 2 register: output payload, held while the consumer stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_y     <= 1'b0;
            out_nv    <= 1'b0;
            out_tag   <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_y   <= y_c;
                out_nv  <= nv_c;
                out_tag <= s1_tag;
            end
        end
    end

endmodule
